dram_arbiter: RTL and testbench

Arbiter sharing the single-port data memory (DRAM: 16-bit address, 8-bit data, registered read) between two requesters: the processor core (port A) and the host transfer engine (port B) that loads operand matrices and dumps results. Sits between those requesters and the DRAM instance in the top level. It drives the DRAM address, data and write-enable lines, and it routes the read data back to whichever port issued the read.

---
 rtl/mm_pkg.sv | 15 +
 rtl/rd_tag_pipe.sv | 35 +++
 rtl/dram_arbiter.sv | 109 ++++++++++
 tb/tb_dram_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and defaults for the data-memory subsystem:
// read-response tags and the default bus geometry.
package mm_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        PORT_A = 2'd1,
        PORT_B = 2'd2
    } port_tag_e;

    localparam int DEF_AW         = 16;
    localparam int DEF_DW         = 8;
    localparam int DEF_RD_LATENCY = 1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Tracks outstanding DRAM reads: one tag per accepted command, shifted in
// lockstep with the DRAM read latency, decoded into per-port rvalid.
import mm_pkg::*;

module rd_tag_pipe #(
    parameter int DEPTH = DEF_RD_LATENCY
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  port_tag_e tag_i,
    output logic      a_rvalid_o,
    output logic      b_rvalid_o,
    output logic      busy_o
);

    port_tag_e tag_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= NONE;
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy_o = busy_o | (tag_q[i] != NONE);
    end

    assign a_rvalid_o = (tag_q[DEPTH-1] == PORT_A);
    assign b_rvalid_o = (tag_q[DEPTH-1] == PORT_B);

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter between the core (A) and the host transfer engine (B)
// for the single-port DRAM, with a B burst lock and read-data routing.
import mm_pkg::*;

module dram_arbiter #(
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    input  logic [DW-1:0] mem_q,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          busy
);

    logic          last_b_q;   // 1: B won the most recent grant
    logic          b_won_q;    // B was granted in the previous cycle
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          locked;
    port_tag_e     tag_d;

    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        tag_d     = NONE;
        // A lock raised during contention only takes hold once B has won.
        locked    = b_won_q & b_lock & b_req;

        if (!rst) begin
            if (locked) begin
                b_gnt = 1'b1;
            end else if (a_req && b_req) begin
                a_gnt = last_b_q;
                b_gnt = ~last_b_q;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end

        if (a_gnt) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_we    = a_we;
            tag_d     = a_we ? NONE : PORT_A;
        end else if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_we    = b_we;
            tag_d     = b_we ? NONE : PORT_B;
        end

        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b_q <= 1'b1;
            b_won_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            b_won_q <= b_gnt;
            if (a_gnt || b_gnt) begin
                last_b_q <= b_gnt;
                addr_q   <= mem_addr;
                wdata_q  <= mem_wdata;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk_i      (clk),
        .rst_i      (rst),
        .tag_i      (tag_d),
        .a_rvalid_o (a_rvalid),
        .b_rvalid_o (b_rvalid),
        .busy_o     (busy)
    );

    assign rdata = mem_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 3) share one stimulus,
// each backed by its own behavioural DRAM preloaded with addr[7:0]^0xA5.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a_req, a_we, b_req, b_we, b_lock;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;

    logic        a_gnt1, b_gnt1, a_rv1, b_rv1, mwe1, busy1;
    logic [7:0]  rdata1, mwd1, q1;
    logic [15:0] maddr1;
    logic        a_gnt3, b_gnt3, a_rv3, b_rv3, mwe3, busy3;
    logic [7:0]  rdata3, mwd3;
    logic [15:0] maddr3;

    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem3 [0:65535];
    logic [7:0]  q3p  [0:2];
    logic        init_done = 1'b0;

    int checks = 0;
    int errors = 0;

    dram_arbiter #(.RD_LATENCY(1), .AW(16), .DW(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_lock(b_lock), .mem_q(q1),
        .a_gnt(a_gnt1), .b_gnt(b_gnt1), .a_rvalid(a_rv1), .b_rvalid(b_rv1),
        .rdata(rdata1), .mem_addr(maddr1), .mem_wdata(mwd1), .mem_we(mwe1),
        .busy(busy1)
    );

    dram_arbiter #(.RD_LATENCY(3), .AW(16), .DW(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_lock(b_lock), .mem_q(q3p[2]),
        .a_gnt(a_gnt3), .b_gnt(b_gnt3), .a_rvalid(a_rv3), .b_rvalid(b_rv3),
        .rdata(rdata3), .mem_addr(maddr3), .mem_wdata(mwd3), .mem_we(mwe3),
        .busy(busy3)
    );

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) begin
                mem1[i] <= i[7:0] ^ 8'hA5;
                mem3[i] <= i[7:0] ^ 8'hA5;
            end
            init_done <= 1'b1;
        end else begin
            if (mwe1) mem1[maddr1] <= mwd1;
            if (mwe3) mem3[maddr3] <= mwd3;
            q1     <= mem1[maddr1];
            q3p[0] <= mem3[maddr3];
            q3p[1] <= q3p[0];
            q3p[2] <= q3p[1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int agn, ng, nrv1, nrv3;
        logic ea, eb;

        rst = 1'b1; b_lock = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 8'hFF;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0020; b_wdata = 8'hEE;

        // Reset held with both ports requesting writes.
        repeat (3) begin
            @(negedge clk); #2;
            chk("rst_agnt", a_gnt1, 0);   chk("rst_bgnt", b_gnt1, 0);
            chk("rst_arv", a_rv1, 0);     chk("rst_brv", b_rv1, 0);
            chk("rst_busy", busy1, 0);    chk("rst_we", mwe1, 0);
            chk("rst_addr", maddr1, 0);   chk("rst_wd", mwd1, 0);
            chk("rst_busy3", busy3, 0);   chk("rst_agnt3", a_gnt3, 0);
        end

        // Contention: A reads 0x0010, B reads 0x0020 for 8 cycles, then drain.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rst = 1'b0; a_we = 1'b0; b_we = 1'b0;
            a_req = (k < 8); b_req = (k < 8);
            #2;
            chk("ct_agnt", a_gnt1, (k < 8) && (k % 2 == 0));
            chk("ct_bgnt", b_gnt1, (k < 8) && (k % 2 == 1));
            if (k < 8) chk("ct_addr", maddr1, (k % 2 == 0) ? 16'h0010 : 16'h0020);
            ea = (k >= 1) && (k <= 8) && ((k - 1) % 2 == 0);
            eb = (k >= 1) && (k <= 8) && ((k - 1) % 2 == 1);
            chk("ct_arv1", a_rv1, ea);  chk("ct_brv1", b_rv1, eb);
            if (ea || eb) chk("ct_rd1", rdata1, ea ? 8'hB5 : 8'h85);
            ea = (k >= 3) && (k <= 10) && ((k - 3) % 2 == 0);
            eb = (k >= 3) && (k <= 10) && ((k - 3) % 2 == 1);
            chk("ct_arv3", a_rv3, ea);  chk("ct_brv3", b_rv3, eb);
            if (ea || eb) chk("ct_rd3", rdata3, ea ? 8'hB5 : 8'h85);
            chk("ct_busy1", busy1, (k >= 1) && (k <= 8));
            chk("ct_busy3", busy3, (k >= 1) && (k <= 10));
        end

        // B writes 0x5A to 0x0100, A reads it back next cycle.
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0100; b_wdata = 8'h5A;
        #2;
        chk("wr_bgnt", b_gnt1, 1); chk("wr_agnt", a_gnt1, 0);
        chk("wr_we", mwe1, 1); chk("wr_addr", maddr1, 16'h0100); chk("wr_wd", mwd1, 8'h5A);
        @(negedge clk);
        b_req = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0100; a_wdata = 8'h33;
        #2;
        chk("wr_rd_agnt", a_gnt1, 1); chk("wr_rd_we", mwe1, 0);
        @(negedge clk);
        a_req = 1'b0;
        #2;
        chk("wr_arv1", a_rv1, 1); chk("wr_rdata1", rdata1, 8'h5A);
        chk("hold_addr", maddr1, 16'h0100); chk("hold_wd", mwd1, 8'h33);
        chk("hold_we", mwe1, 0); chk("hold_gnt", a_gnt1, 0);
        @(negedge clk); #2;
        chk("wr_arv1_off", a_rv1, 0); chk("wr_arv3_early", a_rv3, 0);
        @(negedge clk); #2;
        chk("wr_arv3", a_rv3, 1); chk("wr_rdata3", rdata3, 8'h5A);

        // Locked 16-cycle B write burst while A keeps requesting.
        agn = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
            b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1;
            b_addr = 16'h0200 + 16'(i); b_wdata = 8'(i);
            #2;
            if (a_gnt1) agn++;
            chk("lk_bgnt", b_gnt1, 1);
        end
        chk("lk_a_count", agn, 0);
        @(negedge clk);
        b_req = 1'b0; b_lock = 1'b0;
        #2;
        chk("lk_release_agnt", a_gnt1, 1);
        @(negedge clk);
        a_req = 1'b0;
        #2;
        chk("lk_arv1", a_rv1, 1); chk("lk_rd1", rdata1, 8'hB5);
        @(negedge clk); #2;
        @(negedge clk); #2;
        chk("lk_arv3", a_rv3, 1); chk("lk_rd3", rdata3, 8'hB5);

        // Lock raised during contention before B has won does not hold.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0300; b_lock = 1'b0;
        #2;
        chk("lr_bgnt0", b_gnt1, 1);
        @(negedge clk);
        b_req = 1'b0;
        #2;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0400; b_req = 1'b1; b_lock = 1'b1;
        #2;
        chk("lr_agnt", a_gnt1, 1);
        @(negedge clk); #2;
        chk("lr_bgnt1", b_gnt1, 1);
        @(negedge clk); #2;
        chk("lr_locked_b", b_gnt1, 1); chk("lr_locked_a", a_gnt1, 0);
        @(negedge clk);
        b_lock = 1'b0;
        #2;
        chk("lr_unlock_a", a_gnt1, 1);
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        #2;

        // Reset with reads in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_req = 1'b1; a_addr = 16'h0010;
            #2;
            chk("mf_agnt", a_gnt1, 1);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("mf_rst_gnt", a_gnt1, 0); chk("mf_rst_addr", maddr1, 0);
        @(negedge clk);
        rst = 1'b0; a_req = 1'b0;
        #2;
        chk("mf_busy3", busy3, 0); chk("mf_busy1", busy1, 0);
        chk("mf_arv3", a_rv3, 0); chk("mf_brv3", b_rv3, 0);
        chk("mf_addr", maddr1, 0);
        repeat (2) begin
            @(negedge clk); #2;
            chk("mf_arv3_late", a_rv3, 0); chk("mf_arv1_late", a_rv1, 0);
        end

        // Single requester: A reads every cycle for 10 cycles.
        ng = 0; nrv1 = 0; nrv3 = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            a_req = (k < 10); a_addr = 16'h0020; b_req = 1'b0;
            #2;
            if (a_gnt1) ng++;
            if (a_rv1) nrv1++;
            if (a_rv3) nrv3++;
            chk("sg_agnt", a_gnt1, k < 10);
            chk("sg_arv1", a_rv1, (k >= 1) && (k <= 10));
            chk("sg_arv3", a_rv3, (k >= 3) && (k <= 12));
            chk("sg_brv1", b_rv1, 0); chk("sg_brv3", b_rv3, 0);
            if (a_rv1) chk("sg_rd1", rdata1, 8'h85);
        end
        chk("sg_ngnt", ng, 10); chk("sg_nrv1", nrv1, 10); chk("sg_nrv3", nrv3, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
